// File: rtl/count_nb.sv
// Programmable-modulus up/down counter with load, wrap or saturate at the limit,
// a one-cycle terminal-count pulse and a sticky limit-event flag.
module count_nb #(
  parameter int                WIDTH   = 8,
  parameter int                SAT     = 0,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             l,
  input  logic             s_s,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] c_r;
  logic             tc_r;
  logic             ovf_r;
  logic [WIDTH-1:0] c_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_nxt_s;

  // Next-state selection: load beats counting, counting beats hold.
  always_comb begin
    c_nxt_s   = c_r;
    tc_nxt_s  = 1'b0;
    ovf_nxt_s = ovf_r;
    if (l) begin
      c_nxt_s   = (d <= lim) ? d : lim;
      ovf_nxt_s = 1'b0;
    end else if (s_s) begin
      if (up) begin
        if (c_r < lim) begin
          c_nxt_s = c_r + ONE;
        end else begin
          // At or above the limit: wrap to zero or pin at the limit.
          c_nxt_s   = (SAT != 0) ? lim : ZERO;
          tc_nxt_s  = 1'b1;
          ovf_nxt_s = 1'b1;
        end
      end else begin
        if (c_r == ZERO) begin
          c_nxt_s   = (SAT != 0) ? ZERO : lim;
          tc_nxt_s  = 1'b1;
          ovf_nxt_s = 1'b1;
        end else if (c_r > lim) begin
          // Limit lowered below the count: snap back into range, not an event.
          c_nxt_s = lim;
        end else begin
          c_nxt_s = c_r - ONE;
        end
      end
    end else begin
      c_nxt_s   = c_r;
      tc_nxt_s  = 1'b0;
      ovf_nxt_s = ovf_r;
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      c_r   <= RST_VAL;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      c_r   <= c_nxt_s;
      tc_r  <= tc_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign c   = c_r;
  assign tc  = tc_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_count_nb.sv
// Bench for count_nb: a wrapping instance and a saturating instance share stimulus;
// expectations go into a scoreboard queue and are checked after each clock edge.
module tb_count_nb;

  logic       clk = 1'b0;
  logic       clr, l, s_s, up;
  logic [7:0] d, lim;
  logic [7:0] a_c, b_c;
  logic       a_tc, a_ovf, b_tc, b_ovf;

  always #5 clk = ~clk;

  count_nb #(.WIDTH(8), .SAT(0), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d), .lim(lim),
    .c(a_c), .tc(a_tc), .ovf(a_ovf));

  count_nb #(.WIDTH(8), .SAT(1), .RST_VAL(8'h07)) dut_b (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d), .lim(lim),
    .c(b_c), .tc(b_tc), .ovf(b_ovf));

  typedef struct {
    bit         sel_b;
    logic [7:0] c;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  typedef struct {
    logic       clr, l, s_s, up;
    logic [7:0] d, lim;
    logic [7:0] ac; logic atc, aovf;
    logic [7:0] bc; logic btc, bovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   total = 0;
  int   bad   = 0;

  task automatic drive(input logic i_clr, input logic i_l, input logic i_s,
                       input logic i_up, input logic [7:0] i_d, input logic [7:0] i_lim);
    clr = i_clr; l = i_l; s_s = i_s; up = i_up; d = i_d; lim = i_lim;
  endtask

  task automatic expect_out(input bit sel_b, input logic [7:0] ec, input logic etc,
                            input logic eovf, input string name);
    exp_t e;
    e.sel_b = sel_b; e.c = ec; e.tc = etc; e.ovf = eovf; e.name = name;
    sb.push_back(e);
  endtask

  // Advance one rising edge, then compare every pending expectation on the falling edge.
  task automatic tick();
    exp_t       e;
    logic [7:0] ac;
    logic       atc, aovf;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      ac   = e.sel_b ? b_c   : a_c;
      atc  = e.sel_b ? b_tc  : a_tc;
      aovf = e.sel_b ? b_ovf : a_ovf;
      total++;
      if (ac !== e.c || atc !== e.tc || aovf !== e.ovf) begin
        bad++;
        $display("FAIL %s dut_%s: got c=%h tc=%b ovf=%b, want c=%h tc=%b ovf=%b",
                 e.name, e.sel_b ? "b" : "a", ac, atc, aovf, e.c, e.tc, e.ovf);
      end
    end
  endtask

  logic [7:0] sat_c[5];
  logic       sat_tc[5];
  logic [7:0] ec;

  initial begin
    //           clr   l     s     up    d      lim    A:c    tc    ovf   B:c    tc    ovf
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hFF, 8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h10, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 8'h01, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05, 8'h01, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h03, 8'h01, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h03, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};

    sat_c  = '{8'h04, 8'h05, 8'h05, 8'h05, 8'h05};
    sat_tc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].clr, vecs[i].l, vecs[i].s_s, vecs[i].up, vecs[i].d, vecs[i].lim);
      expect_out(1'b0, vecs[i].ac, vecs[i].atc, vecs[i].aovf, $sformatf("vec%0d", i));
      expect_out(1'b1, vecs[i].bc, vecs[i].btc, vecs[i].bovf, $sformatf("vec%0d", i));
      tick();
    end

    // Saturating instance pressing the limit, then the limit lowered under it.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h05);
    expect_out(1'b1, 8'h03, 1'b0, 1'b0, "sat_load");
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05);
      expect_out(1'b1, sat_c[i], sat_tc[i], (i >= 2) ? 1'b1 : 1'b0, $sformatf("sat_up%0d", i));
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02);
    expect_out(1'b1, 8'h02, 1'b1, 1'b1, "sat_lim_drop");
    tick();

    // Full wrap sweep of the wrapping instance.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF);
    expect_out(1'b0, 8'h00, 1'b0, 1'b0, "wrap_rst");
    tick();
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
      ec = 8'(i + 1);
      expect_out(1'b0, ec, (i == 255) ? 1'b1 : 1'b0, (i >= 255) ? 1'b1 : 1'b0,
                 $sformatf("wrap%0d", i));
      tick();
    end

    // Load while enabled clears ovf, then 16 counts reach the wrap.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hFF);
    expect_out(1'b0, 8'hF0, 1'b0, 1'b0, "load_f0");
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
      ec = 8'(8'hF1 + i);
      expect_out(1'b0, ec, (i == 15) ? 1'b1 : 1'b0, (i == 15) ? 1'b1 : 1'b0,
                 $sformatf("f0_up%0d", i));
      tick();
    end

    // Down-count with modulus 10 from zero.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09);
    expect_out(1'b0, 8'h00, 1'b0, 1'b0, "down_rst");
    tick();
    for (int k = 1; k <= 11; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09);
      ec = (k == 1 || k == 11) ? 8'h09 : 8'(10 - k);
      expect_out(1'b0, ec, (k == 1 || k == 11) ? 1'b1 : 1'b0, 1'b1, $sformatf("down%0d", k));
      tick();
    end

    // A clr glitch between edges must not reset anything.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09);
    #2 clr = 1'b1;
    expect_out(1'b0, 8'h09, 1'b0, 1'b1, "clr_glitch");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_nb.md
COUNT_NB -- requirements
Module: count_nb

Interface
REQ-001 Parameter WIDTH, default 8, counter and data width in bits (legal range 2..32).
REQ-002 Parameter SAT, default 0, limit behaviour: 0 = wrap, 1 = saturate.
REQ-003 Parameter RST_VAL, default 0, value of c after reset.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port clr  input  1  synchronous, active-low reset; sampled on clk rising edge only.
REQ-006 Port l  input  1  synchronous load strobe, active-high.
REQ-007 Port s_s  input  1  start/stop: 1 = count enabled, 0 = hold.
REQ-008 Port up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-009 Port d  input  WIDTH  load data.
REQ-010 Port lim  input  WIDTH  programmable upper count limit (modulus minus one).
REQ-011 Port c  output  WIDTH  current count, registered.
REQ-012 Port tc  output  1  terminal-count pulse, registered, one cycle per limit event.
REQ-013 Port ovf  output  1  sticky limit-event flag, registered.

Function
REQ-014 Per-edge priority SHALL be: clr low > l high > s_s high (count) > hold.
REQ-015 Load SHALL set c to d if d <= lim, else to lim (clamp); tc SHALL be 0 and ovf SHALL clear in the same edge; s_s and up are ignored.
REQ-016 Load SHALL take effect at the first rising edge where l=1 is sampled; c shows the loaded value after that edge (latency 1).
REQ-017 Up-count (s_s=1, up=1, c < lim) SHALL set c to c+1.
REQ-018 Up-count with c >= lim is a limit event: SAT=0 sets c to 0; SAT=1 holds c at lim (and forces c to lim if c > lim).
REQ-019 Down-count (s_s=1, up=0, c > 0) SHALL set c to c-1, except when c > lim: then c SHALL be set to lim.
REQ-020 Down-count with c == 0 is a limit event: SAT=0 sets c to lim; SAT=1 holds c at 0.
REQ-021 On every limit event tc SHALL be 1 for exactly the following cycle and ovf SHALL be set; in SAT=1 mode each enabled cycle held at the limit is a new event (tc stays 1 while pressing the limit).
REQ-022 On every non-event cycle (hold, normal count, load, reset) tc SHALL be 0.
REQ-023 ovf SHALL remain 1 until clr low or a load; counting never clears it.
REQ-024 lim == 0: every enabled cycle is a limit event and c SHALL stay 0.
REQ-025 lim changed while running SHALL take effect on the next edge with no glitch; c > lim is handled per REQ-018/REQ-019.
REQ-026 s_s=0 with l=0 SHALL hold c and ovf unchanged and drive tc to 0.
REQ-027 Direction change SHALL take effect on the same edge up is sampled; no dead cycle.
REQ-028 Arithmetic SHALL be unsigned modulo 2^WIDTH; no X propagation from unused states.

Reset
REQ-029 With clr=0 at a rising edge: c = RST_VAL, tc = 0, ovf = 0, overriding l and s_s.
REQ-030 clr low between edges SHALL have no effect until the next rising edge (synchronous).
REQ-031 Reset asserted mid-count SHALL abort counting; counting resumes from RST_VAL on the first edge with clr=1 and s_s=1.
REQ-032 RST_VAL greater than lim at runtime SHALL be corrected by the next enabled count per REQ-018/REQ-019.

Verification (WIDTH=8, SAT=0, lim=8'hFF unless stated)
REQ-033 clr=0 for 2 edges with l=1, s_s=1 -> c=8'h00, tc=0, ovf=0 after each edge.
REQ-034 s_s=1, up=1 from 0 for 256 edges -> c steps 00..FF then 00; tc=1 only the cycle after FF->00; ovf=1 thereafter.
REQ-035 d=8'hF0, l=1 one edge while s_s=1 -> c=F0, ovf cleared; then 16 up edges -> c=00, tc pulse once.
REQ-036 lim=8'h09, up=0 from c=0 -> c sequence 09,08,...,00,09; tc pulse on each 00->09.
REQ-037 SAT=1, lim=8'h05, up=1 from 03, 5 edges -> c=04,05,05,05,05; tc=0,0,1,1,1; lower lim to 02 -> c=02 next edge.
REQ-038 clr=0 on the same edge as l=1 and a limit event -> c=RST_VAL, tc=0, ovf=0.
